// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, one RAM read per cycle, 2-entry instruction buffer toward decode.
// Optional FETCH_FAST_REDIRECT_EN: issue the redirect target in the redirect cycle itself.
module instr_fetch_unit #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic              halt,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] ram_add,
    output logic              ram_r_w,
    output logic              ram_enable,
    output logic              ram_ce,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflightPc_q, inflightPc_d;
    logic [1:0]        count_q, count_d;
    logic              rdPtr_q, rdPtr_d;
    logic              wrPtr_q, wrPtr_d;
    logic [DATA_W-1:0] fifoData_q [2];
    logic [DATA_W-1:0] fifoData_d [2];
    logic [ADDR_W-1:0] fifoPc_q [2];
    logic [ADDR_W-1:0] fifoPc_d [2];

    logic              pop;
    logic              push;
    logic              credit;
    logic              issue;
    logic [ADDR_W-1:0] issueAddr;
    logic [2:0]        occupancy;

    assign instr_valid = (count_q != 2'd0);
    assign instr       = fifoData_q[rdPtr_q];
    assign instr_pc    = fifoPc_q[rdPtr_q];
    assign ram_r_w     = 1'b0;
    assign ram_ce      = ce;

    // Credit counts buffered plus in-flight entries so a returning read always has a slot.
    assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, instr_valid & instr_ready};
    assign credit    = (occupancy < 3'd2);
    assign pop       = instr_valid & instr_ready & ~redirect;
    assign push      = inflight_q & ~redirect;

    // rst_n gates the request so ram_enable drops the moment reset is asserted.
`ifdef FETCH_FAST_REDIRECT_EN
    assign issue     = rst_n & ~halt & (redirect | credit);
    assign issueAddr = redirect ? redirect_pc : pc_q;
`else
    assign issue     = rst_n & ~halt & ~redirect & credit;
    assign issueAddr = pc_q;
`endif

    assign ram_enable = issue;
    assign ram_add    = issue ? issueAddr : pc_q;

    always_comb begin
        pc_d         = pc_q;
        inflight_d   = inflight_q;
        inflightPc_d = inflightPc_q;
        count_d      = count_q;
        rdPtr_d      = rdPtr_q;
        wrPtr_d      = wrPtr_q;
        fifoData_d   = fifoData_q;
        fifoPc_d     = fifoPc_q;
        if (ce) begin
            if (redirect) begin
                count_d    = 2'd0;
                rdPtr_d    = 1'b0;
                wrPtr_d    = 1'b0;
                pc_d       = redirect_pc;
                inflight_d = 1'b0;
            end else begin
                if (push) begin
                    fifoData_d[wrPtr_q] = ram_data_out;
                    fifoPc_d[wrPtr_q]   = inflightPc_q;
                    wrPtr_d             = ~wrPtr_q;
                end
                if (pop) begin
                    rdPtr_d = ~rdPtr_q;
                end
                count_d = count_q + 2'(push) - 2'(pop);
            end
            if (issue) begin
                pc_d         = ADDR_W'(issueAddr + 1'b1);
                inflight_d   = 1'b1;
                inflightPc_d = issueAddr;
            end else begin
                inflight_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            inflight_q   <= 1'b0;
            inflightPc_q <= '0;
            count_q      <= 2'd0;
            rdPtr_q      <= 1'b0;
            wrPtr_q      <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifoData_q[i] <= '0;
                fifoPc_q[i]   <= '0;
            end
        end else begin
            pc_q         <= pc_d;
            inflight_q   <= inflight_d;
            inflightPc_q <= inflightPc_d;
            count_q      <= count_d;
            rdPtr_q      <= rdPtr_d;
            wrPtr_q      <= wrPtr_d;
            fifoData_q   <= fifoData_d;
            fifoPc_q     <= fifoPc_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: RAM models return 16'hA000 + address one cycle after a read.
// Second instance uses RESET_PC=62 to exercise PC wrap-around.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        ce;
    logic        halt;
    logic        redirect;
    logic [5:0]  redirect_pc;
    logic [5:0]  ram_add;
    logic        ram_r_w;
    logic        ram_enable;
    logic        ram_ce;
    logic [15:0] ram_data_out;
    logic [15:0] instr;
    logic [5:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    logic [5:0]  wRamAdd;
    logic        wRamRw;
    logic        wRamEnable;
    logic        wRamCe;
    logic [15:0] wRamData;
    logic [15:0] wInstr;
    logic [5:0]  wInstrPc;
    logic        wInstrValid;

    int checks = 0;
    int errors = 0;

`ifdef FETCH_FAST_REDIRECT_EN
    localparam int RedirLat = 2;
`else
    localparam int RedirLat = 3;
`endif

    instr_fetch_unit #(.ADDR_W(6), .DATA_W(16), .RESET_PC(6'd0)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .halt(halt),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .ram_add(ram_add), .ram_r_w(ram_r_w), .ram_enable(ram_enable), .ram_ce(ram_ce),
        .ram_data_out(ram_data_out),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready)
    );

    instr_fetch_unit #(.ADDR_W(6), .DATA_W(16), .RESET_PC(6'd62)) u_wrap (
        .clk(clk), .rst_n(rst_n), .ce(ce), .halt(1'b0),
        .redirect(1'b0), .redirect_pc(6'd0),
        .ram_add(wRamAdd), .ram_r_w(wRamRw), .ram_enable(wRamEnable), .ram_ce(wRamCe),
        .ram_data_out(wRamData),
        .instr(wInstr), .instr_pc(wInstrPc), .instr_valid(wInstrValid), .instr_ready(instr_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (ram_ce && ram_enable && !ram_r_w) ram_data_out <= 16'hA000 + {10'd0, ram_add};
        if (wRamCe && wRamEnable && !wRamRw) wRamData <= 16'hA000 + {10'd0, wRamAdd};
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic doReset(input logic ready);
        rst_n = 1'b0;
        ce = 1'b1;
        halt = 1'b0;
        redirect = 1'b0;
        redirect_pc = 6'd0;
        instr_ready = ready;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ce = 1'b1;
        halt = 1'b0;
        redirect = 1'b0;
        redirect_pc = 6'd0;
        instr_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b exp 0", instr_valid); end
        checks++; if (instr !== 16'h0000) begin errors++; $display("[TB] FAIL reset_instr got %h exp 0000", instr); end
        checks++; if (instr_pc !== 6'd0) begin errors++; $display("[TB] FAIL reset_pc got %0d exp 0", instr_pc); end
        checks++; if (ram_enable !== 1'b0) begin errors++; $display("[TB] FAIL reset_ram_enable got %b exp 0", ram_enable); end
        checks++; if (ram_add !== 6'd0) begin errors++; $display("[TB] FAIL reset_ram_add got %0d exp 0", ram_add); end
        checks++; if (ram_r_w !== 1'b0) begin errors++; $display("[TB] FAIL reset_ram_r_w got %b exp 0", ram_r_w); end
        checks++; if (wRamAdd !== 6'd62) begin errors++; $display("[TB] FAIL reset_wrap_ram_add got %0d exp 62", wRamAdd); end
        checks++; if (wRamRw !== 1'b0) begin errors++; $display("[TB] FAIL reset_wrap_r_w got %b exp 0", wRamRw); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        doReset(1'b1);
        checks++; if (ram_enable !== 1'b1) begin errors++; $display("[TB] FAIL stream_first_issue got %b exp 1", ram_enable); end
        checks++; if (ram_add !== 6'd0) begin errors++; $display("[TB] FAIL stream_first_add got %0d exp 0", ram_add); end
        tick();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_latency_valid got %b exp 0", instr_valid); end
        checks++; if (ram_add !== 6'd1) begin errors++; $display("[TB] FAIL stream_second_add got %0d exp 1", ram_add); end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL stream_valid[%0d] got %b exp 1", i, instr_valid); end
            checks++; if (instr !== 16'hA000 + 16'(i)) begin errors++; $display("[TB] FAIL stream_instr[%0d] got %h exp %h", i, instr, 16'hA000 + 16'(i)); end
            checks++; if (instr_pc !== 6'(i)) begin errors++; $display("[TB] FAIL stream_pc[%0d] got %0d exp %0d", i, instr_pc, i); end
        end
    endtask

    task automatic test_backpressure();
        doReset(1'b0);
        tick();
        tick();
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_first_valid got %b exp 1", instr_valid); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (instr !== 16'hA000) begin errors++; $display("[TB] FAIL bp_head_instr[%0d] got %h exp A000", k, instr); end
            checks++; if (instr_pc !== 6'd0) begin errors++; $display("[TB] FAIL bp_head_pc[%0d] got %0d exp 0", k, instr_pc); end
            checks++; if (ram_enable !== 1'b0) begin errors++; $display("[TB] FAIL bp_stall_enable[%0d] got %b exp 0", k, ram_enable); end
        end
        instr_ready = 1'b1;
        #1;
        checks++; if (ram_enable !== 1'b1) begin errors++; $display("[TB] FAIL bp_resume_enable got %b exp 1", ram_enable); end
        checks++; if (ram_add !== 6'd2) begin errors++; $display("[TB] FAIL bp_resume_add got %0d exp 2", ram_add); end
        for (int i = 1; i < 5; i++) begin
            tick();
            checks++; if (instr !== 16'hA000 + 16'(i)) begin errors++; $display("[TB] FAIL bp_drain_instr[%0d] got %h exp %h", i, instr, 16'hA000 + 16'(i)); end
            checks++; if (instr_pc !== 6'(i)) begin errors++; $display("[TB] FAIL bp_drain_pc[%0d] got %0d exp %0d", i, instr_pc, i); end
        end
    endtask

    task automatic test_wrap();
        logic [5:0] expPc;
        doReset(1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            expPc = 6'(62 + i);
            checks++; if (wInstrValid !== 1'b1) begin errors++; $display("[TB] FAIL wrap_valid[%0d] got %b exp 1", i, wInstrValid); end
            checks++; if (wInstrPc !== expPc) begin errors++; $display("[TB] FAIL wrap_pc[%0d] got %0d exp %0d", i, wInstrPc, expPc); end
            checks++; if (wInstr !== 16'hA000 + {10'd0, expPc}) begin errors++; $display("[TB] FAIL wrap_instr[%0d] got %h exp %h", i, wInstr, 16'hA000 + {10'd0, expPc}); end
        end
    endtask

    task automatic test_redirect();
        doReset(1'b0);
        tick();
        tick();
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL redir_pre_valid got %b exp 1", instr_valid); end
        redirect = 1'b1;
        redirect_pc = 6'd20;
        #1;
`ifdef FETCH_FAST_REDIRECT_EN
        checks++; if (ram_enable !== 1'b1 || ram_add !== 6'd20) begin errors++; $display("[TB] FAIL redir_fast_issue got en=%b add=%0d exp en=1 add=20", ram_enable, ram_add); end
`else
        checks++; if (ram_enable !== 1'b0) begin errors++; $display("[TB] FAIL redir_no_issue got %b exp 0", ram_enable); end
`endif
        tick();
        redirect = 1'b0;
        for (int k = 1; k < RedirLat; k++) begin
            checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_flush_valid[%0d] got %b exp 0", k, instr_valid); end
            tick();
        end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL redir_target_valid got %b exp 1", instr_valid); end
        checks++; if (instr !== 16'hA014) begin errors++; $display("[TB] FAIL redir_target_instr got %h exp A014", instr); end
        checks++; if (instr_pc !== 6'd20) begin errors++; $display("[TB] FAIL redir_target_pc got %0d exp 20", instr_pc); end
        instr_ready = 1'b1;
        for (int i = 21; i < 23; i++) begin
            tick();
            checks++; if (instr !== 16'hA000 + 16'(i)) begin errors++; $display("[TB] FAIL redir_follow_instr[%0d] got %h exp %h", i, instr, 16'hA000 + 16'(i)); end
            checks++; if (instr_pc !== 6'(i)) begin errors++; $display("[TB] FAIL redir_follow_pc[%0d] got %0d exp %0d", i, instr_pc, i); end
        end
    endtask

    task automatic test_ce_halt();
        doReset(1'b1);
        tick();
        tick();
        tick();
        checks++; if (instr !== 16'hA001) begin errors++; $display("[TB] FAIL ce_pre_instr got %h exp A001", instr); end
        ce = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (instr_valid !== 1'b1 || instr !== 16'hA001 || instr_pc !== 6'd1) begin
                errors++; $display("[TB] FAIL ce_frozen[%0d] got v=%b %h/%0d exp v=1 A001/1", k, instr_valid, instr, instr_pc);
            end
        end
        ce = 1'b1;
        for (int i = 2; i < 4; i++) begin
            tick();
            checks++; if (instr !== 16'hA000 + 16'(i) || instr_pc !== 6'(i)) begin
                errors++; $display("[TB] FAIL ce_resume[%0d] got %h/%0d exp %h/%0d", i, instr, instr_pc, 16'hA000 + 16'(i), i);
            end
        end
        halt = 1'b1;
        #1;
        checks++; if (ram_enable !== 1'b0) begin errors++; $display("[TB] FAIL halt_enable got %b exp 0", ram_enable); end
        tick();
        checks++; if (instr_valid !== 1'b1 || instr !== 16'hA004 || instr_pc !== 6'd4) begin
            errors++; $display("[TB] FAIL halt_drain got v=%b %h/%0d exp v=1 A004/4", instr_valid, instr, instr_pc);
        end
        tick();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL halt_empty got %b exp 0", instr_valid); end
        tick();
        checks++; if (instr_valid !== 1'b0 || ram_enable !== 1'b0) begin
            errors++; $display("[TB] FAIL halt_idle got v=%b en=%b exp 0 0", instr_valid, ram_enable);
        end
        halt = 1'b0;
    endtask

    task automatic test_async_reset();
        doReset(1'b1);
        repeat (4) tick();
        checks++; if (instr_valid !== 1'b1 || instr !== 16'hA002) begin
            errors++; $display("[TB] FAIL areset_pre got v=%b %h exp v=1 A002", instr_valid, instr);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL areset_valid got %b exp 0", instr_valid); end
        checks++; if (ram_enable !== 1'b0) begin errors++; $display("[TB] FAIL areset_enable got %b exp 0", ram_enable); end
        checks++; if (ram_add !== 6'd0) begin errors++; $display("[TB] FAIL areset_add got %0d exp 0", ram_add); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tick();
        tick();
        checks++; if (instr_valid !== 1'b1 || instr !== 16'hA000 || instr_pc !== 6'd0) begin
            errors++; $display("[TB] FAIL areset_restart0 got v=%b %h/%0d exp v=1 A000/0", instr_valid, instr, instr_pc);
        end
        tick();
        checks++; if (instr !== 16'hA001 || instr_pc !== 6'd1) begin
            errors++; $display("[TB] FAIL areset_restart1 got %h/%0d exp A001/1", instr, instr_pc);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ce = 1'b1;
        halt = 1'b0;
        redirect = 1'b0;
        redirect_pc = 6'd0;
        instr_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_wrap();
        test_redirect();
        test_ce_halt();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
